video_line_fetch: RTL and testbench

VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

---
 rtl/poly94_video_pkg.sv | 17 +
 rtl/fifo_sync.sv | 56 +++++
 rtl/video_line_fetch.sv | 147 ++++++++++++++
 tb/tb_video_line_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly94_video_pkg.sv
// Shared types and defaults for the video scanline fetch path.
package poly94_video_pkg;

  localparam int WORDS_PER_LINE_DEF = 320;
  localparam int BURST_LEN_DEF      = 8;
  localparam int FIFO_DEPTH_DEF     = 64;
  localparam int ADDR_W             = 24;
  localparam int DATA_W             = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with flush; reads 0 when empty.
module fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/video_line_fetch.sv
// Fetches one scanline from SDRAM in fixed bursts into a pixel FIFO.
module video_line_fetch
  import poly94_video_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int BURST_LEN      = BURST_LEN_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              line_start_i,
  input  logic [ADDR_W-1:0] line_addr_x16_i,
  output logic              video_sdram_rd,
  output logic [ADDR_W-1:0] video_sdram_addr_x16,
  input  logic              video_sdram_rdy,
  input  logic              video_sdram_resp_valid,
  input  logic [DATA_W-1:0] video_sdram_rdata,
  output logic              video_sdram_ack,
  input  logic              pix_rd_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_empty_o,
  output logic              underrun_o
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WL_W   = $clog2(WORDS_PER_LINE + 1);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  fetch_state_e      state_q;
  logic              rd_q, ack_q;
  logic [ADDR_W-1:0] addr_q, fetch_addr_q, restart_addr_q;
  logic [WL_W-1:0]   words_left_q;
  logic [BEAT_W-1:0] beat_q;
  logic              restart_q, discard_q;
  logic              underrun_q, underrun_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_push;
  logic              credit_ok, fetch_go, burst_last;

  // Only one burst is ever in flight, so in IDLE the FIFO count already covers all fetched data.
  assign credit_ok  = (int'(fifo_count) + BURST_LEN) <= FIFO_DEPTH;
  assign fetch_go   = (words_left_q != '0) && credit_ok;
  assign burst_last = video_sdram_resp_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign fifo_push  = video_sdram_resp_valid && (state_q == ST_DATA) && !discard_q;

  fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (line_start_i),
    .push_i  (fifo_push),
    .wdata_i (video_sdram_rdata),
    .pop_i   (pix_rd_i),
    .rdata_o (pix_data_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: all state below updates with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      rd_q           <= 1'b0;
      ack_q          <= 1'b0;
      addr_q         <= '0;
      fetch_addr_q   <= '0;
      restart_addr_q <= '0;
      words_left_q   <= '0;
      beat_q         <= '0;
      restart_q      <= 1'b0;
      discard_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_start_i) begin
            fetch_addr_q <= line_addr_x16_i;
            words_left_q <= WL_W'(WORDS_PER_LINE);
          end else if (fetch_go) begin
            state_q <= ST_REQ;
            rd_q    <= 1'b1;
            addr_q  <= fetch_addr_q;
          end
        end
        ST_REQ: begin
          if (line_start_i) begin
            restart_q      <= 1'b1;
            restart_addr_q <= line_addr_x16_i;
            discard_q      <= 1'b1;
          end
          // A posted request cannot be withdrawn; rd stays high until accepted.
          if (video_sdram_rdy) begin
            state_q      <= ST_DATA;
            rd_q         <= 1'b0;
            beat_q       <= '0;
            fetch_addr_q <= fetch_addr_q + ADDR_W'(BURST_LEN);
            words_left_q <= words_left_q - WL_W'(BURST_LEN);
          end
        end
        ST_DATA: begin
          if (line_start_i) begin
            restart_q      <= 1'b1;
            restart_addr_q <= line_addr_x16_i;
            discard_q      <= 1'b1;
          end
          if (video_sdram_resp_valid) beat_q <= beat_q + BEAT_W'(1);
          if (burst_last) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        ST_ACK: begin
          state_q   <= ST_IDLE;
          ack_q     <= 1'b0;
          restart_q <= 1'b0;
          discard_q <= 1'b0;
          if (line_start_i) begin
            fetch_addr_q <= line_addr_x16_i;
            words_left_q <= WL_W'(WORDS_PER_LINE);
          end else if (restart_q) begin
            fetch_addr_q <= restart_addr_q;
            words_left_q <= WL_W'(WORDS_PER_LINE);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A new line clears the sticky flag even if the same cycle pops an empty FIFO.
  assign underrun_d = line_start_i               ? 1'b0 :
                      (pix_rd_i && fifo_empty)   ? 1'b1 : underrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end

  assign video_sdram_rd       = rd_q;
  assign video_sdram_ack      = ack_q;
  assign video_sdram_addr_x16 = addr_q;
  assign pix_empty_o          = fifo_empty;
  assign underrun_o           = underrun_q;

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch with a behavioural arbiter/SDRAM responder.
module tb_video_line_fetch;

  localparam int BURST = 8;

  logic        clk, rst;
  logic        line_start;
  logic [23:0] line_addr;
  logic        rd, rdy, resp_valid, ack;
  logic [23:0] addr;
  logic [15:0] rdata;
  logic        pix_rd;
  logic [15:0] pix_data;
  logic        pix_empty, underrun;

  int n_checks = 0;
  int n_errors = 0;

  video_line_fetch dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .line_start_i           (line_start),
    .line_addr_x16_i        (line_addr),
    .video_sdram_rd         (rd),
    .video_sdram_addr_x16   (addr),
    .video_sdram_rdy        (rdy),
    .video_sdram_resp_valid (resp_valid),
    .video_sdram_rdata      (rdata),
    .video_sdram_ack        (ack),
    .pix_rd_i               (pix_rd),
    .pix_data_o             (pix_data),
    .pix_empty_o            (pix_empty),
    .underrun_o             (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [23:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Arbiter + SDRAM responder: rdy after arb_delay cycles of rd, then BURST back-to-back beats.
  int          arb_delay = 0;
  int          arb_phase = 0;
  int          arb_wait  = 0;
  int          arb_beat  = 0;
  logic [23:0] arb_addr  = '0;
  logic [23:0] req_log [$];

  initial begin
    rdy = 1'b0; resp_valid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdy = 1'b0; resp_valid = 1'b0; arb_phase = 0; arb_wait = 0;
      end else begin
        case (arb_phase)
          0: if (rd) begin
               if (arb_wait >= arb_delay) begin
                 rdy = 1'b1; arb_addr = addr; req_log.push_back(addr); arb_phase = 1;
               end else arb_wait++;
             end
          1: begin
               rdy = 1'b0; arb_wait = 0; arb_beat = 0;
               resp_valid = 1'b1; rdata = word_of(arb_addr); arb_phase = 2;
             end
          2: if (arb_beat == BURST-1) begin
               resp_valid = 1'b0; arb_phase = 3;
             end else begin
               arb_beat++; rdata = word_of(arb_addr + 24'(arb_beat));
             end
          default: if (!ack) arb_phase = 0;
        endcase
      end
    end
  end

  int ack_cnt = 0, ack_run = 0, ack_run_max = 0, rd_ack_both = 0;
  initial forever begin
    @(negedge clk);
    if (ack) begin
      ack_run++;
      if (ack_run == 1) ack_cnt++;
      if (ack_run > ack_run_max) ack_run_max = ack_run;
      if (rd) rd_ack_both++;
    end else ack_run = 0;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_line(input logic [23:0] a, input logic pop);
    line_addr = a; line_start = 1'b1; pix_rd = pop;
    tick();
    line_start = 1'b0; pix_rd = 1'b0;
  endtask

  int          exp_idx  = 0;
  int          seq_errs = 0;
  logic [23:0] seq_base = '0;

  task automatic pop_one();
    if (pix_data !== word_of(seq_base + 24'(exp_idx))) seq_errs++;
    exp_idx++;
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
  endtask

  initial begin
    int n, errs, viol, base;
    rst = 1'b1; line_start = 1'b0; line_addr = '0; pix_rd = 1'b0;
    #1;
    check("rst_rd", 32'(rd), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_empty", 32'(pix_empty), 1);
    check("rst_underrun", 32'(underrun), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Fill from 0x001000 with the pixel side idle: eight bursts then stop.
    pulse_line(24'h001000, 1'b0);
    n = 0;
    for (int i = 0; i < 2 && !rd; i++) tick();
    check("first_rd_latency", 32'(rd), 1);
    for (int i = 0; i < 400 && req_log.size() < 8; i++) tick();
    repeat (40) tick();
    check("fill_bursts", 32'(req_log.size()), 8);
    for (int k = 0; k < 8 && k < req_log.size(); k++)
      check($sformatf("fill_addr%0d", k), 32'(req_log[k]), 32'h001000 + 32'(8*k));
    check("fill_acks", 32'(ack_cnt), 8);
    check("ack_one_cycle", 32'(ack_run_max), 1);
    check("rd_ack_overlap", 32'(rd_ack_both), 0);
    check("fill_head", 32'(pix_data), 32'(word_of(24'h001000)));

    // New line at 0x003000 flushes the full FIFO; drain it with a 3-cycle rdy delay.
    arb_delay = 3;
    req_log.delete();
    pulse_line(24'h003000, 1'b0);
    check("flush_on_start", 32'(pix_empty), 1);
    n = 0; errs = 0;
    for (int i = 0; i < 8000 && n < 320; i++) begin
      if (!pix_empty) begin
        if (pix_data !== word_of(24'h003000 + 24'(n))) errs++;
        n++;
        pix_rd = 1'b1;
      end else pix_rd = 1'b0;
      if (n < 320) tick();
    end
    tick();
    pix_rd = 1'b0;
    check("line_words", 32'(n), 320);
    check("line_order_errs", 32'(errs), 0);
    check("line_underrun", 32'(underrun), 0);
    repeat (30) tick();
    check("line_bursts", 32'(req_log.size()), 40);
    if (req_log.size() == 40) check("line_last_addr", 32'(req_log[39]), 32'h003138);
    check("line_done_empty", 32'(pix_empty), 1);
    check("line_done_idle", 32'(rd), 0);

    // Pop while empty: sticky underrun, data reads zero.
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    check("underrun_set", 32'(underrun), 1);
    check("underrun_data", 32'(pix_data), 0);
    check("underrun_empty", 32'(pix_empty), 1);
    tick();
    check("underrun_sticky", 32'(underrun), 1);

    // line_start beats a same-cycle empty pop; then restart on the 3rd beat of the first burst.
    arb_delay = 0;
    req_log.delete();
    pulse_line(24'h004000, 1'b1);
    check("underrun_clear_prio", 32'(underrun), 0);
    for (int i = 0; i < 50 && !(arb_phase == 2 && arb_beat == 2); i++) tick();
    check("restart_at_beat3", 32'(arb_beat), 2);
    base = ack_cnt;
    pulse_line(24'h002000, 1'b0);
    viol = 0;
    for (int i = 0; i < 20 && arb_phase != 0; i++) begin
      if (!pix_empty) viol++;
      tick();
    end
    check("discard_empty_viol", 32'(viol), 0);
    for (int i = 0; i < 50 && req_log.size() < 2; i++) tick();
    check("restart_acks", 32'(ack_cnt - base), 1);
    check("restart_empty", 32'(pix_empty), 1);
    check("restart_reqs", 32'(req_log.size()), 2);
    if (req_log.size() >= 2) begin
      check("restart_old_addr", 32'(req_log[0]), 32'h004000);
      check("restart_new_addr", 32'(req_log[1]), 32'h002000);
    end
    for (int i = 0; i < 400 && req_log.size() < 9; i++) tick();
    repeat (20) tick();
    check("restart_fill_reqs", 32'(req_log.size()), 9);
    check("restart_head", 32'(pix_data), 32'(word_of(24'h002000)));

    // Push and pop together at count 63.
    arb_delay = 2;
    seq_base = 24'h002000; exp_idx = 0; seq_errs = 0;
    repeat (8) pop_one();
    for (int i = 0; i < 50 && !(arb_phase == 2 && arb_beat == 7); i++) tick();
    check("pp_at_last_beat", 32'(arb_beat), 7);
    pop_one();
    repeat (20) tick();
    check("pp_count63_no_req", 32'(req_log.size()), 10);
    repeat (7) pop_one();
    for (int i = 0; i < 10 && req_log.size() < 11; i++) tick();
    check("pp_count56_req", 32'(req_log.size()), 11);
    if (req_log.size() >= 11) check("pp_req_addr", 32'(req_log[10]), 32'h002048);
    check("pp_order_errs", 32'(seq_errs), 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 50 && !(arb_phase == 2 && arb_beat == 3); i++) tick();
    check("rst_mid_data", 32'(arb_phase), 2);
    base = ack_cnt;
    rst = 1'b1;
    #1;
    check("arst_rd", 32'(rd), 0);
    check("arst_ack", 32'(ack), 0);
    check("arst_addr", 32'(addr), 0);
    check("arst_empty", 32'(pix_empty), 1);
    check("arst_underrun", 32'(underrun), 0);
    check("arst_data", 32'(pix_data), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("arst_no_ack", 32'(ack_cnt - base), 0);
    check("arst_idle", 32'(rd), 0);

    arb_delay = 0;
    req_log.delete();
    pulse_line(24'h007000, 1'b0);
    for (int i = 0; i < 400 && req_log.size() < 8; i++) tick();
    repeat (20) tick();
    check("post_rst_reqs", 32'(req_log.size()), 8);
    if (req_log.size() >= 1) check("post_rst_addr", 32'(req_log[0]), 32'h007000);
    check("post_rst_acks", 32'(ack_cnt - base), 8);
    check("post_rst_head", 32'(pix_data), 32'(word_of(24'h007000)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
